mem_sched_arbiter: RTL and testbench
====================================

// Module: mem_sched_arbiter
// PURPOSE
//  Clocked arbiter sharing the single main-memory port between I-cache read, D-cache read and D-cache write.
//  Registered FSM with a 4-phase memory handshake, write-before-read ordering on the same line,
//  I-cache anti-starvation and a stuck-transaction watchdog. Sits between the L1 caches and main memory.
// PARAMETERS
//  ADDR_W      32   address width (matches `REG_SIZE)
//  DATA_W      128  line/data width (matches `WIDTH)
//  LINE_OFF    4    low address bits ignored for same-line comparison
//  STARVE_MAX  4    consecutive D-side grants tolerated while ic_read_req waits
//  TIMEOUT     255  max cycles in BUSY before timeout_err sets (8-bit counter)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  ic_read_req    in   1       I-cache read request, level, held until ic_read_ack
//  ic_read_addr   in   ADDR_W  I-cache read address
//  ic_read_ack    out  1       one-cycle completion pulse
//  ic_read_data   out  DATA_W  registered read line, held until next IC read completes
//  dc_read_req    in   1       D-cache read request, level
//  dc_read_addr   in   ADDR_W  D-cache read address
//  dc_read_ack    out  1       one-cycle completion pulse
//  dc_read_data   out  DATA_W  registered read line, held until next DC read completes
//  dc_write_req   in   1       D-cache write request, level
//  dc_write_addr  in   ADDR_W  write address
//  dc_write_data  in   DATA_W  write line
//  dc_write_ack   out  1       one-cycle completion pulse
//  mem_enable     out  1       memory request, held until mem_ack sampled high
//  mem_rw         out  1       1 = read, 0 = write
//  mem_addr       out  ADDR_W  registered address
//  mem_data_in    out  DATA_W  registered write data
//  mem_ack        in   1       memory ack, level; must return low after mem_enable drops
//  mem_data_out   in   DATA_W  read data, valid while mem_ack=1
//  grant_id       out  2       00 none, 01 IC read, 10 DC write, 11 DC read
//  timeout_err    out  1       sticky; cleared only by reset
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, starve_cnt = 0, wd_cnt = 0. Mid-transaction reset abandons the
//   memory access; mem_enable falls immediately, no ack is issued.
//  FSM: IDLE -> BUSY -> DRAIN -> IDLE.
//  IDLE: evaluate requests each cycle. On a winner, next edge: latch addr/data/rw into mem_*, set mem_enable=1,
//   set grant_id, go BUSY. Idle-to-mem_enable latency is 1 cycle.
//  Priority: dc_write > dc_read > ic_read, except when starve_cnt == STARVE_MAX and ic_read_req=1: IC wins.
//  Hazard: if IC is promoted, dc_write_req=1 and ic_read_addr[ADDR_W-1:LINE_OFF] == dc_write_addr[same],
//   the write wins and starve_cnt is kept (not cleared).
//  starve_cnt: +1 on each D-side grant while ic_read_req=1 (saturates at STARVE_MAX); cleared on IC grant
//   or when ic_read_req=0 in IDLE.
//  BUSY: mem_* held stable; wd_cnt counts up. On mem_ack=1: capture mem_data_out into the granted port's read
//   register (reads only), pulse that port's ack for exactly 1 cycle, mem_enable=0, go DRAIN.
//   If wd_cnt reaches TIMEOUT: timeout_err=1, mem_enable=0, no ack, go DRAIN.
//  DRAIN: grant_id held. Go IDLE when mem_ack=0 AND the granted req=0. No new grant is made here.
//  A request dropped while BUSY is ignored; the transaction completes and ack still pulses.
//  Simultaneous requests in one IDLE cycle: exactly one grant; losers keep requesting.
//  Back-to-back: minimum 4 cycles per transaction with a 1-cycle-ack memory.
//  mem_data_out is sampled only on the BUSY cycle where mem_ack=1.
// STRUCTURE
//  define.v: add `ARB_IDLE/`ARB_BUSY/`ARB_DRAIN state codes and `GNT_NONE/`GNT_IC/`GNT_DW/`GNT_DR.
//  Sub-module arb_prio_select: combinational winner select (priority, starvation override, same-line hazard)
//   -> 2-bit grant. FSM, counters and data registers stay in mem_sched_arbiter.
// TESTING
//  1. dc_write_req and ic_read_req rise together -> grant_id=10 first; dc_write_ack pulses once; then IC is served.
//  2. DC read at 0x40, memory returns 0xDEAD..BEEF -> dc_read_data equals it; dc_read_ack is 1 cycle wide.
//  3. Continuous DC traffic plus ic_read_req held -> IC granted after exactly 4 D-side grants.
//  4. Starve case with a pending write at 0x1230 and IC read at 0x1238 -> write granted before IC.
//  5. mem_ack never asserted -> timeout_err=1 after 255 BUSY cycles; no ack; returns to IDLE once reqs drop.
//  6. Reset asserted mid-BUSY -> mem_enable=0 and grant_id=00 without waiting for a clock edge; no ack pulse.

Source files
------------

// File: rtl/mem_sched_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM state codes and grant identifiers.
package mem_sched_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_IC   = 2'b01,
      GNT_DW   = 2'b10,
      GNT_DR   = 2'b11
   } grant_e;

endpackage

// File: rtl/mem_sched_arbiter_prio_select.sv
// Combinational winner select: fixed priority dc_write > dc_read > ic_read, with an
// I-cache starvation override that still yields to a pending write to the same line.
module mem_sched_arbiter_prio_select
   import mem_sched_arbiter_pkg::*;
#(
   parameter int LINE_W = 28
) (
   input  logic              ic_req_i,
   input  logic              dr_req_i,
   input  logic              dw_req_i,
   input  logic [LINE_W-1:0] ic_line_i,
   input  logic [LINE_W-1:0] dw_line_i,
   input  logic              starved_i,
   output grant_e            grant_o
);

   logic same_line;

   assign same_line = (ic_line_i == dw_line_i);

   always_comb begin
      grant_o = GNT_NONE;
      if (starved_i && ic_req_i) begin
         // a promoted IC read must not overtake a write to its own line
         grant_o = (dw_req_i && same_line) ? GNT_DW : GNT_IC;
      end else if (dw_req_i) begin
         grant_o = GNT_DW;
      end else if (dr_req_i) begin
         grant_o = GNT_DR;
      end else if (ic_req_i) begin
         grant_o = GNT_IC;
      end
   end

endmodule

// File: rtl/mem_sched_arbiter.sv
// Shares the main-memory port between I-cache read, D-cache read and D-cache write.
// state | meaning
// IDLE  | evaluate requests, launch winner next edge
// BUSY  | mem_enable held, waiting for mem_ack or watchdog expiry
// DRAIN | wait for mem_ack low and granted request dropped
module mem_sched_arbiter
   import mem_sched_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 128,
   parameter int LINE_OFF   = 4,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ic_read_req_i,
   input  logic [ADDR_W-1:0] ic_read_addr_i,
   output logic              ic_read_ack_o,
   output logic [DATA_W-1:0] ic_read_data_o,
   input  logic              dc_read_req_i,
   input  logic [ADDR_W-1:0] dc_read_addr_i,
   output logic              dc_read_ack_o,
   output logic [DATA_W-1:0] dc_read_data_o,
   input  logic              dc_write_req_i,
   input  logic [ADDR_W-1:0] dc_write_addr_i,
   input  logic [DATA_W-1:0] dc_write_data_i,
   output logic              dc_write_ack_o,
   output logic              mem_enable_o,
   output logic              mem_rw_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_in_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_out_i,
   output logic [1:0]        grant_id_o,
   output logic              timeout_err_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_e        state_q, state_d;
   grant_e            grant_q, grant_d, win;
   logic              mem_en_q, mem_en_d;
   logic              mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
   logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
   logic              ic_ack_q, ic_ack_d;
   logic              dr_ack_q, dr_ack_d;
   logic              dw_ack_q, dw_ack_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [7:0]        wd_q, wd_d;
   logic              to_err_q, to_err_d;
   logic              starved;
   logic              granted_req;

   assign starved = (starve_q == SW'(STARVE_MAX));

   mem_sched_arbiter_prio_select #(
      .LINE_W (ADDR_W - LINE_OFF)
   ) u_prio (
      .ic_req_i  (ic_read_req_i),
      .dr_req_i  (dc_read_req_i),
      .dw_req_i  (dc_write_req_i),
      .ic_line_i (ic_read_addr_i[ADDR_W-1:LINE_OFF]),
      .dw_line_i (dc_write_addr_i[ADDR_W-1:LINE_OFF]),
      .starved_i (starved),
      .grant_o   (win)
   );

   always_comb begin
      case (grant_q)
         GNT_IC:  granted_req = ic_read_req_i;
         GNT_DW:  granted_req = dc_write_req_i;
         GNT_DR:  granted_req = dc_read_req_i;
         default: granted_req = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      mem_en_d    = mem_en_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ic_rdata_d  = ic_rdata_q;
      dc_rdata_d  = dc_rdata_q;
      ic_ack_d    = 1'b0;
      dr_ack_d    = 1'b0;
      dw_ack_d    = 1'b0;
      starve_d    = starve_q;
      wd_d        = wd_q;
      to_err_d    = to_err_q;
      case (state_q)
         ARB_IDLE: begin
            grant_d = GNT_NONE;
            if (!ic_read_req_i) starve_d = '0;
            if (win != GNT_NONE) begin
               state_d  = ARB_BUSY;
               grant_d  = win;
               mem_en_d = 1'b1;
               wd_d     = '0;
               case (win)
                  GNT_IC: begin
                     mem_rw_d   = 1'b1;
                     mem_addr_d = ic_read_addr_i;
                     starve_d   = '0;
                  end
                  GNT_DR: begin
                     mem_rw_d   = 1'b1;
                     mem_addr_d = dc_read_addr_i;
                  end
                  default: begin
                     mem_rw_d    = 1'b0;
                     mem_addr_d  = dc_write_addr_i;
                     mem_wdata_d = dc_write_data_i;
                  end
               endcase
               // saturating count of D-side wins while the I-cache waits
               if (win != GNT_IC && ic_read_req_i && !starved) starve_d = starve_q + 1'b1;
            end
         end
         ARB_BUSY: begin
            wd_d = wd_q + 8'd1;
            if (mem_ack_i) begin
               mem_en_d = 1'b0;
               state_d  = ARB_DRAIN;
               case (grant_q)
                  GNT_IC: begin
                     ic_rdata_d = mem_data_out_i;
                     ic_ack_d   = 1'b1;
                  end
                  GNT_DR: begin
                     dc_rdata_d = mem_data_out_i;
                     dr_ack_d   = 1'b1;
                  end
                  default: dw_ack_d = 1'b1;
               endcase
            end else if (wd_d == 8'(TIMEOUT)) begin
               to_err_d = 1'b1;
               mem_en_d = 1'b0;
               state_d  = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (!mem_ack_i && !granted_req) begin
               state_d = ARB_IDLE;
               grant_d = GNT_NONE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = GNT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ARB_IDLE;
         grant_q     <= GNT_NONE;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ic_rdata_q  <= '0;
         dc_rdata_q  <= '0;
         ic_ack_q    <= 1'b0;
         dr_ack_q    <= 1'b0;
         dw_ack_q    <= 1'b0;
         starve_q    <= '0;
         wd_q        <= '0;
         to_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         mem_en_q    <= mem_en_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ic_rdata_q  <= ic_rdata_d;
         dc_rdata_q  <= dc_rdata_d;
         ic_ack_q    <= ic_ack_d;
         dr_ack_q    <= dr_ack_d;
         dw_ack_q    <= dw_ack_d;
         starve_q    <= starve_d;
         wd_q        <= wd_d;
         to_err_q    <= to_err_d;
      end
   end

   assign ic_read_ack_o  = ic_ack_q;
   assign ic_read_data_o = ic_rdata_q;
   assign dc_read_ack_o  = dr_ack_q;
   assign dc_read_data_o = dc_rdata_q;
   assign dc_write_ack_o = dw_ack_q;
   assign mem_enable_o   = mem_en_q;
   assign mem_rw_o       = mem_rw_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_data_in_o  = mem_wdata_q;
   assign grant_id_o     = grant_q;
   assign timeout_err_o  = to_err_q;

endmodule

// File: tb/tb_mem_sched_arbiter.sv
// Directed bench for mem_sched_arbiter: ordering, read capture, starvation, hazard, watchdog, reset.
module tb_mem_sched_arbiter;

   localparam int AW = 32;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          ic_read_req_i, dc_read_req_i, dc_write_req_i;
   logic [AW-1:0] ic_read_addr_i, dc_read_addr_i, dc_write_addr_i;
   logic [DW-1:0] dc_write_data_i;
   logic          ic_read_ack_o, dc_read_ack_o, dc_write_ack_o;
   logic [DW-1:0] ic_read_data_o, dc_read_data_o;
   logic          mem_enable_o, mem_rw_o, mem_ack_i;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_in_o, mem_data_out_i;
   logic [1:0]    grant_id_o;
   logic          timeout_err_o;

   int n_vec = 0;
   int n_err = 0;
   int ic_acks, dr_acks, dw_acks, en_cycles, n_g;
   logic [1:0]    g_log [16];
   logic          rw_log[16];
   logic [AW-1:0] a_log [16];
   logic [DW-1:0] d_log [16];
   logic [1:0]    prev_gnt;
   logic          stream, mem_auto;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    exp_seq[7];

   always #5 clk = ~clk;

   mem_sched_arbiter dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .ic_read_req_i   (ic_read_req_i),
      .ic_read_addr_i  (ic_read_addr_i),
      .ic_read_ack_o   (ic_read_ack_o),
      .ic_read_data_o  (ic_read_data_o),
      .dc_read_req_i   (dc_read_req_i),
      .dc_read_addr_i  (dc_read_addr_i),
      .dc_read_ack_o   (dc_read_ack_o),
      .dc_read_data_o  (dc_read_data_o),
      .dc_write_req_i  (dc_write_req_i),
      .dc_write_addr_i (dc_write_addr_i),
      .dc_write_data_i (dc_write_data_i),
      .dc_write_ack_o  (dc_write_ack_o),
      .mem_enable_o    (mem_enable_o),
      .mem_rw_o        (mem_rw_o),
      .mem_addr_o      (mem_addr_o),
      .mem_data_in_o   (mem_data_in_o),
      .mem_ack_i       (mem_ack_i),
      .mem_data_out_i  (mem_data_out_i),
      .grant_id_o      (grant_id_o),
      .timeout_err_o   (timeout_err_o)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      ic_acks = 0; dr_acks = 0; dw_acks = 0; en_cycles = 0; n_g = 0;
      for (int i = 0; i < 16; i++) begin
         g_log[i] = '0; rw_log[i] = 1'b0; a_log[i] = '0; d_log[i] = '0;
      end
   endtask

   // One clock: observe at the falling edge, then play memory and cache responders.
   task automatic cyc();
      @(negedge clk);
      if (prev_gnt == 2'b00 && grant_id_o != 2'b00 && n_g < 16) begin
         g_log[n_g]  = grant_id_o;
         rw_log[n_g] = mem_rw_o;
         a_log[n_g]  = mem_addr_o;
         d_log[n_g]  = mem_data_in_o;
         n_g++;
      end
      prev_gnt  = grant_id_o;
      ic_acks   += int'(ic_read_ack_o);
      dr_acks   += int'(dc_read_ack_o);
      dw_acks   += int'(dc_write_ack_o);
      en_cycles += int'(mem_enable_o);
      mem_ack_i      = mem_auto && mem_enable_o;
      mem_data_out_i = mem_rdata;
      if (ic_read_ack_o) ic_read_req_i = 1'b0;
      if (dc_write_ack_o) begin
         dc_write_req_i = 1'b0;
         if (stream) dc_read_req_i = 1'b1;
      end
      if (dc_read_ack_o) begin
         dc_read_req_i = 1'b0;
         if (stream) dc_write_req_i = 1'b1;
      end
   endtask

   task automatic settle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!ic_read_req_i && !dc_read_req_i && !dc_write_req_i && grant_id_o == 2'b00) break;
         cyc();
      end
      chk("settle_idle", {ic_read_req_i, dc_read_req_i, dc_write_req_i, grant_id_o}, '0);
   endtask

   initial begin
      reset_i = 1'b1;
      ic_read_req_i = 1'b0; dc_read_req_i = 1'b0; dc_write_req_i = 1'b0;
      ic_read_addr_i = '0; dc_read_addr_i = '0; dc_write_addr_i = '0; dc_write_data_i = '0;
      mem_ack_i = 1'b0; mem_data_out_i = '0; mem_rdata = '0;
      stream = 1'b0; mem_auto = 1'b1; prev_gnt = 2'b00;
      clear_logs();

      // reset state
      @(negedge clk);
      chk("rst_mem_enable", mem_enable_o, 0);
      chk("rst_grant", grant_id_o, 0);
      chk("rst_acks", {ic_read_ack_o, dc_read_ack_o, dc_write_ack_o}, 0);
      chk("rst_timeout", timeout_err_o, 0);
      chk("rst_mem_addr_rw", {mem_addr_o, mem_rw_o}, 0);
      chk("rst_rdata", {ic_read_data_o, dc_read_data_o}, 0);
      reset_i = 1'b0;
      repeat (2) cyc();

      // 1: write and IC read raised together -> write first
      clear_logs();
      dc_write_addr_i = 32'h0000_0200;
      dc_write_data_i = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
      ic_read_addr_i  = 32'h0000_0300;
      mem_rdata       = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      dc_write_req_i = 1'b1; ic_read_req_i = 1'b1;
      settle(40);
      repeat (2) cyc();
      chk("t1_ngrants", n_g, 2);
      chk("t1_first_grant", g_log[0], 2'b10);
      chk("t1_write_rw", rw_log[0], 1'b0);
      chk("t1_write_addr", a_log[0], 32'h0000_0200);
      chk("t1_write_data", d_log[0], 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004);
      chk("t1_second_grant", g_log[1], 2'b01);
      chk("t1_ic_addr", a_log[1], 32'h0000_0300);
      chk("t1_dw_acks", dw_acks, 1);
      chk("t1_ic_acks", ic_acks, 1);
      chk("t1_ic_data", ic_read_data_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

      // 2: DC read at 0x40
      clear_logs();
      dc_read_addr_i = 32'h0000_0040;
      mem_rdata      = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      dc_read_req_i  = 1'b1;
      settle(40);
      repeat (2) cyc();
      chk("t2_grant", g_log[0], 2'b11);
      chk("t2_rw", rw_log[0], 1'b1);
      chk("t2_addr", a_log[0], 32'h0000_0040);
      chk("t2_dc_data", dc_read_data_o, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
      chk("t2_ack_width", dr_acks, 1);
      chk("t2_ic_data_held", ic_read_data_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

      // 3: continuous D traffic, IC on another line -> IC after 4 D grants
      clear_logs();
      ic_read_addr_i = 32'h0000_0500; dc_write_addr_i = 32'h0000_0600; dc_read_addr_i = 32'h0000_0700;
      stream = 1'b1;
      dc_write_req_i = 1'b1; dc_read_req_i = 1'b1; ic_read_req_i = 1'b1;
      for (int i = 0; i < 100 && ic_acks == 0; i++) cyc();
      stream = 1'b0;
      settle(60);
      exp_seq = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
      chk("t3_ngrants", n_g, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), g_log[i], exp_seq[i]);

      // 4: starved IC at 0x1238 with pending write to 0x1230 -> write still first
      clear_logs();
      ic_read_addr_i = 32'h0000_1238; dc_write_addr_i = 32'h0000_1230; dc_read_addr_i = 32'h0000_0700;
      stream = 1'b1;
      dc_write_req_i = 1'b1; dc_read_req_i = 1'b1; ic_read_req_i = 1'b1;
      for (int i = 0; i < 100 && ic_acks == 0; i++) cyc();
      stream = 1'b0;
      settle(60);
      exp_seq = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11};
      chk("t4_ngrants", n_g, 7);
      for (int i = 0; i < 7; i++) chk($sformatf("t4_grant%0d", i), g_log[i], exp_seq[i]);
      chk("t4_hazard_addr", a_log[4], 32'h0000_1230);

      // 5: memory never acks -> watchdog
      clear_logs();
      mem_auto = 1'b0;
      dc_read_addr_i = 32'h0000_0080;
      dc_read_req_i  = 1'b1;
      for (int i = 0; i < 400 && !timeout_err_o; i++) cyc();
      chk("t5_timeout_set", timeout_err_o, 1'b1);
      chk("t5_busy_cycles", en_cycles, 255);
      chk("t5_mem_enable_low", mem_enable_o, 1'b0);
      repeat (4) cyc();
      chk("t5_drain_hold", grant_id_o, 2'b11);
      dc_read_req_i = 1'b0;
      repeat (3) cyc();
      chk("t5_back_idle", grant_id_o, 2'b00);
      chk("t5_sticky", timeout_err_o, 1'b1);
      chk("t5_no_ack", dr_acks, 0);

      // 6: reset mid-BUSY
      clear_logs();
      ic_read_addr_i = 32'h0000_0900;
      ic_read_req_i  = 1'b1;
      for (int i = 0; i < 10 && !mem_enable_o; i++) cyc();
      chk("t6_busy_entered", mem_enable_o, 1'b1);
      repeat (3) cyc();
      #2 reset_i = 1'b1;
      #1;
      chk("t6_async_enable", mem_enable_o, 1'b0);
      chk("t6_async_grant", grant_id_o, 2'b00);
      chk("t6_timeout_cleared", timeout_err_o, 1'b0);
      ic_read_req_i = 1'b0;
      mem_auto = 1'b1;
      cyc();
      reset_i = 1'b0;
      repeat (5) cyc();
      chk("t6_no_ack", ic_acks, 0);
      chk("t6_idle_after", {mem_enable_o, grant_id_o}, 0);
      chk("t6_ic_data_reset", ic_read_data_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
